// File: rtl/rv_stall_ctrl_pkg.sv
// Shared constants for the uRV stall/flush responder: debug encodings of the
// winning stall priority and the default number of execute-unit requesters.
package rv_stall_ctrl_pkg;

  localparam int RV_N_XREQ = 3;

  typedef enum logic [2:0] {
    PRIO_NONE = 3'd0,
    PRIO_W    = 3'd1,
    PRIO_X    = 3'd2,
    PRIO_KILL = 3'd3,
    PRIO_D    = 3'd4
  } stall_prio_e;

endpackage

// File: rtl/rv_stall_ctrl_if.sv
// Request/control bundle between the pipeline stages (master) and the stall
// responder (slave), plus the debug view of which priority level won.
interface rv_stall_ctrl_if
  import rv_stall_ctrl_pkg::*;
#(
  parameter int N_XREQ = RV_N_XREQ,
  parameter int CNT_W  = 32
);
  // Handshake: there is no valid/ready pair. Requests are levels sampled in
  // the cycle they are raised and the controls answer in that same cycle.
  logic [N_XREQ-1:0] x_stall_req;
  logic              w_stall_req;
  logic              d_stall_req;
  logic              x_kill;

  logic              f_stall;
  logic              d_stall;
  logic              x_stall;
  logic              x_bubble;
  logic              w_bubble;
  logic              f_kill;
  logic              d_kill;
  logic [CNT_W-1:0]  cnt_stall;
  logic [CNT_W-1:0]  cnt_bubble;
  logic              stall_timeout;
  stall_prio_e       prio;

  modport master (
    output x_stall_req, w_stall_req, d_stall_req, x_kill,
    input  f_stall, d_stall, x_stall, x_bubble, w_bubble, f_kill, d_kill,
    input  cnt_stall, cnt_bubble, stall_timeout, prio
  );

  modport slave (
    input  x_stall_req, w_stall_req, d_stall_req, x_kill,
    output f_stall, d_stall, x_stall, x_bubble, w_bubble, f_kill, d_kill,
    output cnt_stall, cnt_bubble, stall_timeout, prio
  );

endinterface

// File: rtl/rv_stall_ctrl_perf_counter.sv
// Free-running performance counter: wraps modulo 2^CNT_W, synchronous clear
// takes precedence over the count enable.
module rv_stall_ctrl_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rv_stall_ctrl.sv
// uRV stall/flush responder: folds execute, writeback and decode hazard requests
// into per-stage stall, bubble and kill controls, with perf counters and a watchdog.
module rv_stall_ctrl
  import rv_stall_ctrl_pkg::*;
#(
  parameter int N_XREQ    = RV_N_XREQ,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rv_stall_ctrl_if.slave bus
);

  localparam int RUN_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;

  logic [N_XREQ-1:0] x_req;
  logic              kill_pending;
  logic              kill_eff;
  stall_prio_e       prio;
  logic              f_stall, d_stall, x_stall;
  logic              x_bubble, w_bubble;
  logic              f_kill, d_kill;
  logic [RUN_W-1:0]  run;
  logic              timeout_q;

  assign x_req    = bus.x_stall_req;
  assign kill_eff = bus.x_kill | kill_pending;

  always_comb begin
    prio     = PRIO_NONE;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    x_stall  = 1'b0;
    x_bubble = 1'b0;
    w_bubble = 1'b0;
    f_kill   = 1'b0;
    d_kill   = 1'b0;
    if (!rst_i) begin
      if (bus.w_stall_req) begin
        prio    = PRIO_W;
        f_stall = 1'b1;
        d_stall = 1'b1;
        x_stall = 1'b1;
      end else if (|x_req) begin
        prio     = PRIO_X;
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        x_stall  = 1'b1;
        w_bubble = 1'b1;
      end else if (kill_eff) begin
        // A redirect squashes F/D, so a load-use hold on D is moot.
        prio   = PRIO_KILL;
        f_kill = 1'b1;
        d_kill = 1'b1;
      end else if (bus.d_stall_req) begin
        prio     = PRIO_D;
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        x_bubble = 1'b1;
      end
    end
  end

  // A kill seen while X is frozen is remembered and applied once X moves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_pending <= 1'b0;
    end else if (prio == PRIO_KILL) begin
      kill_pending <= 1'b0;
    end else if (bus.x_kill && x_stall) begin
      kill_pending <= 1'b1;
    end
  end

  // Watchdog: run length saturates at MAX_STALL-1; the timeout flag is sticky.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run       <= '0;
      timeout_q <= 1'b0;
    end else if (!x_stall) begin
      run <= '0;
    end else if (run == RUN_W'(MAX_STALL - 1)) begin
      timeout_q <= 1'b1;
    end else begin
      run <= run + RUN_W'(1);
    end
  end

  rv_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk_i (clk_i),
    .clr   (rst_i),
    .en    (x_stall),
    .cnt   (bus.cnt_stall)
  );

  rv_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
    .clk_i (clk_i),
    .clr   (rst_i),
    .en    (x_bubble | w_bubble),
    .cnt   (bus.cnt_bubble)
  );

  assign bus.f_stall       = f_stall;
  assign bus.d_stall       = d_stall;
  assign bus.x_stall       = x_stall;
  assign bus.x_bubble      = x_bubble;
  assign bus.w_bubble      = w_bubble;
  assign bus.f_kill        = f_kill;
  assign bus.d_kill        = d_kill;
  assign bus.stall_timeout = timeout_q;
  assign bus.prio          = prio;

endmodule

// File: tb/tb_rv_stall_ctrl.sv
// Directed bench for rv_stall_ctrl: each stimulus cycle pushes its expected
// control/counter vector, a negedge monitor pops and compares it.
module tb_rv_stall_ctrl;

  localparam int N_XREQ    = 3;
  localparam int MAX_STALL = 64;
  localparam int CNT_W     = 4;
  localparam int VW        = 7 + 1 + 2 * CNT_W;

  // {f_stall, d_stall, x_stall, x_bubble, w_bubble, f_kill, d_kill}
  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_W    = 7'b111_0000;
  localparam logic [6:0] C_X    = 7'b111_0100;
  localparam logic [6:0] C_K    = 7'b000_0011;
  localparam logic [6:0] C_D    = 7'b110_1000;

  logic clk;
  logic rst_i;

  rv_stall_ctrl_if #(.N_XREQ(N_XREQ), .CNT_W(CNT_W)) bus ();

  rv_stall_ctrl #(
    .N_XREQ    (N_XREQ),
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0]    exp_q[$];
  int               checks;
  int               errors;
  int               cyc;
  logic [CNT_W-1:0] exp_cs;
  logic [CNT_W-1:0] exp_cb;
  logic             exp_to;
  int               exp_run;

  always @(negedge clk) begin
    logic [VW-1:0] exp_v;
    logic [VW-1:0] got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {bus.f_stall, bus.d_stall, bus.x_stall, bus.x_bubble, bus.w_bubble,
               bus.f_kill, bus.d_kill, bus.stall_timeout, bus.cnt_stall, bus.cnt_bubble};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_%0d ctrl/to/cs/cb: got %b/%b/%0d/%0d required %b/%b/%0d/%0d",
                 cyc, got_v[VW-1 -: 7], got_v[2*CNT_W], got_v[2*CNT_W-1 -: CNT_W],
                 got_v[CNT_W-1:0], exp_v[VW-1 -: 7], exp_v[2*CNT_W],
                 exp_v[2*CNT_W-1 -: CNT_W], exp_v[CNT_W-1:0]);
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N_XREQ-1:0] xr, input logic w, input logic d,
                      input logic k, input logic [6:0] ctrl);
    bus.x_stall_req = xr;
    bus.w_stall_req = w;
    bus.d_stall_req = d;
    bus.x_kill      = k;
    exp_q.push_back({ctrl, exp_to, exp_cs, exp_cb});
    if (ctrl[4]) exp_cs = exp_cs + CNT_W'(1);
    if (ctrl[3] || ctrl[2]) exp_cb = exp_cb + CNT_W'(1);
    if (ctrl[4]) begin
      if (exp_run == MAX_STALL - 1) exp_to = 1'b1;
      else exp_run++;
    end else begin
      exp_run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i           = 1'b1;
    bus.x_stall_req = '1;
    bus.w_stall_req = 1'b1;
    bus.d_stall_req = 1'b1;
    bus.x_kill      = 1'b1;
    for (int i = 0; i < n; i++) begin
      // Counters and the timeout flag are only defined once a reset edge has passed.
      if (i > 0) exp_q.push_back('0);
      @(posedge clk);
      #1;
    end
    rst_i           = 1'b0;
    bus.x_stall_req = '0;
    bus.w_stall_req = 1'b0;
    bus.d_stall_req = 1'b0;
    bus.x_kill      = 1'b0;
    exp_cs  = '0;
    exp_cb  = '0;
    exp_to  = 1'b0;
    exp_run = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    do_reset(3);

    step(3'b000, 0, 0, 0, C_NONE);
    // shifter single pulse, then counters read 1/1
    step(3'b001, 0, 0, 0, C_X);
    step(3'b000, 0, 0, 0, C_NONE);
    // several units at once, then back-to-back pulses
    step(3'b110, 0, 0, 0, C_X);
    step(3'b010, 0, 0, 0, C_X);
    step(3'b100, 0, 0, 0, C_X);
    step(3'b000, 0, 0, 0, C_NONE);
    // load-use alone, load-use with kill, kill alone
    step(3'b000, 0, 1, 0, C_D);
    step(3'b000, 0, 1, 1, C_K);
    step(3'b000, 0, 0, 1, C_K);
    step(3'b000, 0, 0, 0, C_NONE);
    // writeback outranks everything
    step(3'b111, 1, 1, 1, C_W);
    step(3'b000, 0, 0, 0, C_K);
    step(3'b000, 0, 0, 0, C_NONE);
    // kill pulse in cycle 2 of a 4-cycle writeback stall lands in cycle 5 only
    step(3'b000, 1, 0, 0, C_W);
    step(3'b000, 1, 0, 1, C_W);
    step(3'b000, 1, 0, 0, C_W);
    step(3'b000, 1, 0, 0, C_W);
    step(3'b000, 0, 0, 0, C_K);
    step(3'b000, 0, 0, 0, C_NONE);
    // kill held across a stall is applied once
    step(3'b001, 0, 0, 1, C_X);
    step(3'b001, 0, 0, 1, C_X);
    step(3'b000, 0, 0, 0, C_K);
    step(3'b000, 0, 1, 0, C_D);
    step(3'b000, 0, 0, 0, C_NONE);
    // watchdog: 63 stall cycles stay clear, the 64th sets the sticky flag
    for (int i = 0; i < MAX_STALL - 1; i++) step(3'b000, 1, 0, 0, C_W);
    step(3'b000, 1, 0, 0, C_W);
    step(3'b000, 0, 0, 0, C_NONE);
    step(3'b000, 0, 1, 0, C_D);
    step(3'b000, 0, 0, 0, C_NONE);
    // reset clears the flag; 17 stall cycles wrap a 4-bit counter to 1
    do_reset(3);
    for (int i = 0; i < 17; i++) step(3'b001, 0, 0, 0, C_X);
    step(3'b000, 0, 0, 0, C_NONE);
    step(3'b000, 0, 0, 0, C_NONE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
